maxi_read_arbiter: RTL
======================

# maxi_read_arbiter

Two-into-one arbiter for the 64-bit AXI read master port, so that two DMA read requesters inside the accelerator share a single MAXI read channel. It carries the packed `{valid, payload}` handshake of the MAXI ports (valid in the MSB, separate `_ready`). Address requests are granted round-robin. Read beats are routed back to the owning requester through an in-order ownership FIFO.

## Interface
- `DEPTH`, default 4: maximum bursts outstanding, counting the AR holding register; power of two, ≥2.

- `CLK` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `R0_ARADDR` in 33: bit32 valid, [31:0] byte address of requester 0.
- `R0_ARLEN` in 4: burst length-1 of requester 0.
- `R0_ARADDR_ready` out 1: request accepted this cycle.
- `R0_RDATA` out 65: bit64 valid, [63:0] read data to requester 0.
- `R0_RLAST` out 1: last beat of burst.
- `R0_RRESP` out 2: response code.
- `R0_RDATA_ready` in 1: requester 0 accepts the beat.
- `R1_*`: identical set of ports for requester 1.
- `M_ARADDR` out 33: bit32 valid, [31:0] address to the MAXI port.
- `M_ARLEN` out 4: burst length-1.
- `M_ARSIZE` out 2: constant 2'b11 (8 bytes).
- `M_ARBURST` out 2: constant 2'b01 (INCR).
- `M_ARADDR_ready` in 1: the port accepts the address.
- `M_RDATA` in 65: bit64 valid, [63:0] data.
- `M_RLAST` in 1: last beat of burst.
- `M_RRESP` in 2: response code.
- `M_RDATA_ready` out 1: beat accepted.
- `OUTSTANDING` out $clog2(DEPTH)+1: current ownership-FIFO occupancy.
- `ERR` out 1: sticky protocol-error flag.

## Operation
- **AR holding register**: one stage of {valid, addr, len, owner}. It drives `M_ARADDR`/`M_ARLEN` directly.
  - Cleared when `M_ARADDR[32] && M_ARADDR_ready`.
- **Grant condition**: holding register empty, or being accepted this cycle; and ownership FIFO not full.
  - A pop in the same cycle does NOT free a slot for a push.
- **Round-robin selection**: pointer `last` holds the last granted requester.
  - If both requesters are valid, grant `!last`.
  - If only one is valid, grant that one.
  - `last` updates only on a grant.
- `Rx_ARADDR_ready` is combinational and high exactly in the grant cycle for requester x. It is never high while the grant condition is false.
- **On grant**: load the holding register and push the owner ID into the FIFO in the same cycle. `OUTSTANDING` counts bursts not yet fully returned.
- **R routing**, combinational pass-through, FIFO head `h`:
  - `Rh_RDATA` = `M_RDATA`; `Rh_RLAST` = `M_RLAST`; `Rh_RRESP` = `M_RRESP`.
  - The non-owner's `RDATA[64]` is 0.
  - `M_RDATA_ready` = `Rh_RDATA_ready` when the FIFO is non-empty, else 0.
- **Pop**: on a beat accepted with `M_RLAST` = 1.
  - A push and a pop in the same cycle leave `OUTSTANDING` unchanged.
- **ERR**: set when `M_RDATA[64]` = 1 while the FIFO is empty. Cleared only by `reset`.
- **FIFO pointers**: $clog2(DEPTH) bits, wrap modulo DEPTH. Count is a separate register, 0..DEPTH.

## Timing
- **Reset values**:
  - Holding register invalid, so `M_ARADDR` = 0 and `M_ARLEN` = 0.
  - FIFO empty, `OUTSTANDING` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - `ERR` = 0; all `_ready` outputs and `Rx_RDATA` are 0.
- **AR latency**: a request granted in cycle N appears on `M_ARADDR` in cycle N+1.
- **Throughput**: back-to-back grants every cycle while `M_ARADDR_ready` = 1 and the FIFO is not full.
- **R path**: zero latency, no registers.
- **Reset mid-burst**: all outstanding ownership is discarded. The MAXI side must be reset in the same cycle; no drain is performed.
- **Requester-side rules**: `Rx_ARADDR` must hold stable until ready. A request that drops valid before ready is simply never granted.

## Test plan
- **Single burst**: `R0_ARADDR` = {1, 0x1000}, `R0_ARLEN` = 3 → `M_ARADDR` = {1, 0x1000} one cycle after grant. 4 beats (last with RLAST) are routed to R0 only. `OUTSTANDING` goes 0→1→0.
- **Tie**: R0 and R1 valid continuously after reset, `M_ARADDR_ready` = 1 → grant order R0, R1, R0, R1. `OUTSTANDING` saturates at 4 and the grant stalls until a pop.
- **Out-of-order readiness**: R1 granted first, then R0. `R0_RDATA_ready` = 1, `R1_RDATA_ready` = 0 → `M_RDATA_ready` = 0 and R0 sees no data until R1's burst completes.
- **Full with simultaneous pop**: `OUTSTANDING` = 4, RLAST beat accepted while R0 requests → no grant that cycle, grant the next cycle, count 4→3→4.
- **Spurious beat**: `M_RDATA[64]` = 1 with an empty FIFO → `M_RDATA_ready` = 0, `ERR` = 1 and held until `reset`.
- **Reset mid-operation**: `reset` with 2 bursts outstanding and the holding register valid → next cycle `OUTSTANDING` = 0, `M_ARADDR[32]` = 0, `ERR` = 0.

Source files
------------

// File: rtl/maxi_read_arbiter_if.sv
// Bus bundle for the two-requester MAXI read arbiter.
// Handshake rule on every channel: valid is the MSB of the packed
// {valid, payload} word (or a separate valid bit). A transfer happens
// on a rising clock edge where valid and the matching _ready are both
// high. Once valid is raised, the source holds the payload stable until
// that transfer.
// Modport 'slave' is the arbiter's view. Modport 'master' is the view
// of whatever surrounds it: the two requesters and the MAXI port.
interface maxi_read_arbiter_if;
    logic [32:0] R0_ARADDR;
    logic [3:0]  R0_ARLEN;
    logic        R0_ARADDR_ready;
    logic [64:0] R0_RDATA;
    logic        R0_RLAST;
    logic [1:0]  R0_RRESP;
    logic        R0_RDATA_ready;

    logic [32:0] R1_ARADDR;
    logic [3:0]  R1_ARLEN;
    logic        R1_ARADDR_ready;
    logic [64:0] R1_RDATA;
    logic        R1_RLAST;
    logic [1:0]  R1_RRESP;
    logic        R1_RDATA_ready;

    logic [32:0] M_ARADDR;
    logic [3:0]  M_ARLEN;
    logic [1:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic        M_ARADDR_ready;
    logic [64:0] M_RDATA;
    logic        M_RLAST;
    logic [1:0]  M_RRESP;
    logic        M_RDATA_ready;

    modport slave (
        input  R0_ARADDR, R0_ARLEN, R0_RDATA_ready,
        input  R1_ARADDR, R1_ARLEN, R1_RDATA_ready,
        input  M_ARADDR_ready, M_RDATA, M_RLAST, M_RRESP,
        output R0_ARADDR_ready, R0_RDATA, R0_RLAST, R0_RRESP,
        output R1_ARADDR_ready, R1_RDATA, R1_RLAST, R1_RRESP,
        output M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_RDATA_ready
    );

    modport master (
        output R0_ARADDR, R0_ARLEN, R0_RDATA_ready,
        output R1_ARADDR, R1_ARLEN, R1_RDATA_ready,
        output M_ARADDR_ready, M_RDATA, M_RLAST, M_RRESP,
        input  R0_ARADDR_ready, R0_RDATA, R0_RLAST, R0_RRESP,
        input  R1_ARADDR_ready, R1_RDATA, R1_RLAST, R1_RRESP,
        input  M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_RDATA_ready
    );
endinterface

// File: rtl/maxi_read_arbiter.sv
// Two-into-one MAXI read arbiter.
// Address requests are granted round-robin into a single AR holding
// register. The owner of each granted burst is pushed into an in-order
// FIFO. The head of that FIFO steers the read-data beats back, with no
// added latency.
module maxi_read_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    maxi_read_arbiter_if.slave     bus,
    output logic [$clog2(DEPTH):0] OUTSTANDING,
    output logic                   ERR
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // AR holding register. The owner of the held burst already sits in
    // the ownership FIFO, so the register does not store it again.
    logic             hold_vld_q, hold_vld_d;
    logic [31:0]      hold_addr_q, hold_addr_d;
    logic [3:0]       hold_len_q, hold_len_d;
    // Round-robin pointer: the requester granted most recently.
    logic             last_q, last_d;
    // Ownership FIFO: one bit per burst, 0 = requester 0, 1 = requester 1.
    logic [DEPTH-1:0] own_q, own_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic req0_v, req1_v;
    logic fifo_full, fifo_empty;
    logic hold_free, grant, sel;
    logic head, pop;

    // Arbitration. This block also drives the AR-side outputs.
    always_comb begin
        req0_v     = bus.R0_ARADDR[32];
        req1_v     = bus.R1_ARADDR[32];
        fifo_full  = (count_q == CW'(DEPTH));
        fifo_empty = (count_q == '0);
        // A pop in the same cycle does not free a slot for this grant.
        hold_free  = !hold_vld_q || bus.M_ARADDR_ready;
        sel        = (req0_v && req1_v) ? !last_q : req1_v;
        grant      = hold_free && !fifo_full && (req0_v || req1_v);

        bus.R0_ARADDR_ready = grant && !sel;
        bus.R1_ARADDR_ready = grant && sel;
        bus.M_ARADDR        = {hold_vld_q, hold_addr_q};
        bus.M_ARLEN         = hold_len_q;
        bus.M_ARSIZE        = 2'b11;
        bus.M_ARBURST       = 2'b01;
    end

    // Read-data routing. The FIFO head picks the owner of the beat.
    always_comb begin
        head              = own_q[rd_ptr_q];
        bus.R0_RDATA      = '0;
        bus.R0_RLAST      = 1'b0;
        bus.R0_RRESP      = 2'b00;
        bus.R1_RDATA      = '0;
        bus.R1_RLAST      = 1'b0;
        bus.R1_RRESP      = 2'b00;
        bus.M_RDATA_ready = 1'b0;
        if (!fifo_empty) begin
            if (head) begin
                bus.R1_RDATA      = bus.M_RDATA;
                bus.R1_RLAST      = bus.M_RLAST;
                bus.R1_RRESP      = bus.M_RRESP;
                bus.M_RDATA_ready = bus.R1_RDATA_ready;
            end else begin
                bus.R0_RDATA      = bus.M_RDATA;
                bus.R0_RLAST      = bus.M_RLAST;
                bus.R0_RRESP      = bus.M_RRESP;
                bus.M_RDATA_ready = bus.R0_RDATA_ready;
            end
        end
        pop = bus.M_RDATA[64] && bus.M_RDATA_ready && bus.M_RLAST;
    end

    // Next state for the holding register, the FIFO and the error flag.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_addr_d = hold_addr_q;
        hold_len_d  = hold_len_q;
        last_d      = last_q;
        own_d       = own_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = err_q;

        // Clear to zero so that an idle M_ARADDR/M_ARLEN reads as zero.
        if (hold_vld_q && bus.M_ARADDR_ready) begin
            hold_vld_d  = 1'b0;
            hold_addr_d = '0;
            hold_len_d  = '0;
        end
        if (grant) begin
            hold_vld_d      = 1'b1;
            hold_addr_d     = sel ? bus.R1_ARADDR[31:0] : bus.R0_ARADDR[31:0];
            hold_len_d      = sel ? bus.R1_ARLEN : bus.R0_ARLEN;
            last_d          = sel;
            own_d[wr_ptr_q] = sel;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(grant) - CW'(pop);
        // A beat that arrives with no burst outstanding is a protocol error.
        if (bus.M_RDATA[64] && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // State registers. Reset throws away all outstanding ownership.
    always_ff @(posedge CLK) begin
        if (reset) begin
            hold_vld_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_len_q  <= '0;
            last_q      <= 1'b1;
            own_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_addr_q <= hold_addr_d;
            hold_len_q  <= hold_len_d;
            last_q      <= last_d;
            own_q       <= own_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign OUTSTANDING = count_q;
    assign ERR         = err_q;
endmodule
